// File: rtl/param_rom_stream_ctrl.sv
// Read sequencer for the fixed-latency parameter ROMs: issues addresses 0..DEPTH-1 for N passes,
// tags in-flight reads and re-times returned words through a credit-protected valid/ready FIFO.
module param_rom_stream_ctrl #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned PASS_W      = 8,
  localparam int unsigned AWIDTH     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [PASS_W-1:0]     num_passes_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AWIDTH-1:0]     rom_addr_o,
  output logic                  rom_ce_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_out_valid_o,
  input  logic                  data_out_ready_i,
  output logic                  data_out_last_o
);

  localparam int unsigned FIFO_DEPTH = ROM_LATENCY + 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [AWIDTH-1:0]      addr_q, addr_d;
  logic [AWIDTH-1:0]      rom_addr_q, rom_addr_d;
  logic [PASS_W-1:0]      pass_q, pass_d;
  logic [PASS_W-1:0]      passes_q, passes_d;
  logic [ROM_LATENCY-1:0] tag_q, tag_d;
  logic [ROM_LATENCY-1:0] tlast_q, tlast_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  mem_last_q;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  logic issue, issue_last, final_issue, push, pop;
  int   used;

  assign pop  = (count_q != '0) && data_out_ready_i;
  assign push = tag_q[ROM_LATENCY-1];

  // Credits: FIFO occupancy plus every read still in the ROM pipe must fit after this pop.
  always_comb begin
    used        = int'(count_q) + $countones(tag_q) - int'(pop);
    issue       = (state_q == StRun) && (used < int'(FIFO_DEPTH));
    issue_last  = (addr_q == AWIDTH'(DEPTH - 1));
    final_issue = issue && issue_last && (pass_q == passes_q - 1'b1);
  end

  always_comb begin
    tag_d[0]   = issue;
    tlast_d[0] = issue && issue_last;
    for (int i = 1; i < int'(ROM_LATENCY); i++) begin
      tag_d[i]   = tag_q[i-1];
      tlast_d[i] = tlast_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    pass_d     = pass_q;
    passes_d   = passes_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          addr_d   = '0;
          pass_d   = '0;
          passes_d = (num_passes_i == '0) ? PASS_W'(1) : num_passes_i;
        end
      end
      StRun: begin
        if (issue) begin
          rom_addr_d = addr_q;
          if (issue_last) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (final_issue) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave once the last beat has been handed off, so done lands one cycle after it.
        if ((count_d == '0) && (tag_d == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rom_addr_q <= '0;
      pass_q     <= '0;
      passes_q   <= '0;
      tag_q      <= '0;
      tlast_q    <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      pass_q     <= pass_d;
      passes_q   <= passes_d;
      tag_q      <= tag_d;
      tlast_q    <= tlast_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= rom_q_i;
      mem_last_q[wr_ptr_q] <= tlast_q[ROM_LATENCY-1];
    end
  end

  assign rom_ce_o         = 1'b1;
  assign rom_addr_o       = issue ? addr_q : rom_addr_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign data_out_valid_o = (count_q != '0);
  assign data_out_o       = mem_q[rd_ptr_q];
  assign data_out_last_o  = data_out_valid_o && mem_last_q[rd_ptr_q];

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Randomized bench for param_rom_stream_ctrl: a latency-accurate ROM fixture feeds the DUT and an
// expected-beat queue built from the pass/address rules scores the output stream.
module tb_param_rom_stream_ctrl;

  localparam int unsigned DW    = 512;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LAT   = 2;
  localparam int unsigned PW    = 8;
  localparam int unsigned AW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [PW-1:0] num_passes_i = '0;
  logic          busy_o, done_o, rom_ce_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_q_i, data_out_o;
  logic          data_out_valid_o, data_out_last_o;
  logic          data_out_ready_i = 1'b1;

  param_rom_stream_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ROM_LATENCY(LAT),
    .PASS_W     (PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .num_passes_i    (num_passes_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .rom_addr_o      (rom_addr_o),
    .rom_ce_o        (rom_ce_o),
    .rom_q_i         (rom_q_i),
    .data_out_o      (data_out_o),
    .data_out_valid_o(data_out_valid_o),
    .data_out_ready_i(data_out_ready_i),
    .data_out_last_o (data_out_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input int unsigned a);
    logic [DW-1:0] w;
    for (int i = 0; i < int'(DW / 32); i++) begin
      w[i*32 +: 32] = (a * 32'h9E37_79B1) ^ 32'(i);
    end
    return w;
  endfunction

  // ROM fixture: word for the address presented in cycle t is visible in cycle t+LAT.
  logic [AW-1:0] apipe [LAT];
  always_ff @(posedge clk) begin
    if (rom_ce_o) begin
      apipe[0] <= rom_addr_o;
      for (int i = 1; i < int'(LAT); i++) apipe[i] <= apipe[i-1];
    end
  end
  assign rom_q_i = rom_word(int'(apipe[LAT-1]));

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            beat_cyc[$];
  int            beats = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  bit            rand_ready = 1'b0;
  bit            stall = 1'b0;

  // Monitor: scores every handshake, stall stability and done behaviour.
  initial begin
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] e;
    logic          el;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", DW'(data_out_valid_o), DW'(1));
          check_eq("hold_data", data_out_o, prev_data);
          check_eq("hold_last", DW'(data_out_last_o), DW'(prev_last));
        end
        if (data_out_valid_o && data_out_ready_i) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_beat", DW'(1), DW'(0));
          end else begin
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check_eq("beat_data", data_out_o, e);
            check_eq("beat_last", DW'(data_out_last_o), DW'(el));
          end
          beats++;
          beat_cyc.push_back(cyc);
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
          check_eq("done_busy", DW'(busy_o), DW'(0));
          check_eq("done_pending", DW'(exp_q.size()), DW'(0));
        end
        prev_stall = data_out_valid_o && !data_out_ready_i;
        prev_data  = data_out_o;
        prev_last  = data_out_last_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    data_out_ready_i = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic expect_passes(input int p);
    for (int k = 0; k < p; k++) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        exp_q.push_back(rom_word(a));
        exp_last_q.push_back(a == int'(DEPTH) - 1);
      end
    end
  endtask

  // Runs one job to completion; returns the start cycle. stall_cycles holds ready low from the
  // start, restart_at (>=0) pulses a stray start that far into the run.
  task automatic run_stream(input int passes, input int stall_cycles, input int restart_at,
                            output int s_cyc);
    int d0;
    int n;
    expect_passes((passes == 0) ? 1 : passes);
    beats = 0;
    beat_cyc.delete();
    d0 = done_cnt;
    start_i = 1'b1;
    num_passes_i = PW'(passes);
    stall = (stall_cycles > 0);
    s_cyc = cyc;
    tick();
    start_i = 1'b0;
    check_eq("busy_after_start", DW'(busy_o), DW'(1));
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      if (stall_cycles > 0 && n == stall_cycles - 1) begin
        check_eq("stall_addr", DW'(rom_addr_o), DW'(LAT));
        check_eq("stall_valid", DW'(data_out_valid_o), DW'(1));
        check_eq("stall_head", data_out_o, rom_word(0));
        stall = 1'b0;
      end
      start_i = (n == restart_at);
      num_passes_i = start_i ? PW'(5) : PW'(passes);
      tick();
      n++;
    end
    start_i = 1'b0;
    if (done_cnt == d0) check_eq("done_timeout", DW'(0), DW'(1));
    check_eq("beat_total", DW'(beats), DW'(DEPTH * ((passes == 0) ? 1 : passes)));
  endtask

  initial begin
    int s;
    int d0;
    int n;
    int p;
    repeat (3) tick();
    check_eq("rst_busy", DW'(busy_o), DW'(0));
    check_eq("rst_done", DW'(done_o), DW'(0));
    check_eq("rst_valid", DW'(data_out_valid_o), DW'(0));
    check_eq("rst_last", DW'(data_out_last_o), DW'(0));
    check_eq("rst_addr", DW'(rom_addr_o), DW'(0));
    check_eq("rst_ce", DW'(rom_ce_o), DW'(1));
    rst = 1'b0;
    repeat (2) tick();

    // Single pass, full throughput, exact latencies.
    run_stream(1, 0, -1, s);
    check_eq("first_beat_cyc", DW'(beat_cyc[0]), DW'(s + 2 + int'(LAT)));
    check_eq("last_beat_cyc", DW'(beat_cyc[DEPTH-1]), DW'(s + 1 + int'(LAT + DEPTH)));
    check_eq("done_cyc", DW'(done_cyc), DW'(s + 2 + int'(LAT + DEPTH)));

    // Three passes under random backpressure.
    rand_ready = 1'b1;
    run_stream(3, 0, -1, s);
    rand_ready = 1'b0;
    tick();

    // Zero passes behaves as one.
    run_stream(0, 0, -1, s);
    tick();

    // Stray start mid-run is ignored.
    d0 = done_cnt;
    run_stream(1, 0, 10, s);
    repeat (40) tick();
    check_eq("restart_done_cnt", DW'(done_cnt), DW'(d0 + 1));
    check_eq("restart_beats", DW'(beats), DW'(DEPTH));

    // Ready held low for 20 cycles after start.
    run_stream(1, 20, -1, s);
    tick();

    // Reset after beat 10, then a clean job.
    expect_passes(1);
    beats = 0;
    start_i = 1'b1;
    num_passes_i = PW'(1);
    tick();
    start_i = 1'b0;
    n = 0;
    while (beats < 11 && n < 200) begin
      tick();
      n++;
    end
    check_eq("reset_reach_beat10", DW'(beats >= 11), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_busy", DW'(busy_o), DW'(0));
    check_eq("mid_rst_valid", DW'(data_out_valid_o), DW'(0));
    check_eq("mid_rst_last", DW'(data_out_last_o), DW'(0));
    check_eq("mid_rst_done", DW'(done_o), DW'(0));
    check_eq("mid_rst_addr", DW'(rom_addr_o), DW'(0));
    exp_q.delete();
    exp_last_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_valid", DW'(data_out_valid_o), DW'(0));
    end
    run_stream(1, 0, -1, s);
    tick();

    // Random pass counts with random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      p = int'($urandom_range(0, 4));
      run_stream(p, 0, -1, s);
      tick();
    end
    rand_ready = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/param_rom_stream_ctrl.md
# param_rom_stream_ctrl

Read sequencer for the generated parameter ROMs (bias/weight `*_rom` wrappers: fixed-latency, `ce`-gated, address width `$clog2(DEPTH)+1`). On a `start` pulse it issues addresses `0..DEPTH-1` for a programmable number of passes. It tags each in-flight read, captures returned words into a small credit-protected FIFO, and presents them as a true valid/ready stream to the downstream linear/add stage. It replaces the free-running counter with constant-valid scheme: no word is dropped or duplicated under backpressure.

## Interface
- `DATA_WIDTH`, 512, width of one ROM word (e.g. precision × tensor size).
- `DEPTH`, 32, number of ROM words per pass.
- `ROM_LATENCY`, 2, cycles from address presented to `rom_q` valid (≥1).
- `PASS_W`, 8, width of `num_passes`.
- `AWIDTH` (local), `$clog2(DEPTH)+1`.
- `FIFO_DEPTH` (local), `ROM_LATENCY+1`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `num_passes`  in  PASS_W  pass count, sampled with `start`. 0 is treated as 1.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `rom_addr`  out  AWIDTH  ROM address.
- `rom_ce`  out  1  ROM enable, constant 1 so the ROM pipeline never freezes.
- `rom_q`  in  DATA_WIDTH  ROM read data.
- `data_out`  out  DATA_WIDTH  stream data (FIFO head).
- `data_out_valid`  out  1  FIFO non-empty.
- `data_out_ready`  in  1  downstream accept.
- `data_out_last`  out  1  current beat came from address DEPTH-1.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`. Latches passes (0→1) and clears the address and pass counters.
  - RUN→DRAIN in the cycle the final address of the final pass is issued.
  - DRAIN→IDLE when the tag pipe is empty, the FIFO is empty, and no issue is pending. `done` pulses on that transition.
- Issue condition in RUN: `fifo_count + inflight - pop < FIFO_DEPTH`, where `pop = data_out_valid & data_out_ready`. When the condition holds, `rom_addr` carries the issued address in that cycle and a tag bit (plus its last flag) enters a ROM_LATENCY-deep shift register. Otherwise `rom_addr` holds its value and a 0 tag is shifted in.
- Address counter: increments per issue. At DEPTH-1 it wraps to 0 and increments the pass counter.
- Capture: when the tag pipe output is 1, `rom_q` and its last flag are written into the FIFO in that cycle. The credit rule guarantees the FIFO is never full on write.
- FIFO: a push and a pop in the same cycle leave the count unchanged. Output comes from a head register/array with no combinational path from `data_out_ready` to `data_out_valid`.
- `start` in RUN/DRAIN is ignored with no effect.
- `data_out` holds stable while `data_out_valid & !data_out_ready`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `data_out_valid` 0, `data_out_last` 0, `rom_addr` 0, `rom_ce` 1. The FIFO and tag pipe are cleared, so reads in flight at reset are discarded.
- `start` accepted in cycle S:
  - `busy` is 1 and the first issue (addr 0) occurs in S+1.
  - First `data_out_valid` is in S+2+ROM_LATENCY (S+4 at default).
- Throughput: 1 beat/cycle sustained while `data_out_ready` is held 1.
- Total beats = DEPTH × passes.
- `done` appears in the cycle after the final handshake, and `busy` is 0 in that same cycle.
- A new `start` is accepted in the `done` cycle at the earliest.
- A reset asserted mid-RUN returns all outputs to reset values on the next edge. No stale beat may appear afterward.

## Test plan
- Single pass, DEPTH=32, ready=1, ROM word = address:
  - start at S → data 0..31 on consecutive cycles from S+4.
  - last on beat 31.
  - done at S+36, busy low at S+36.
- Backpressure, ready random 50%, 3 passes:
  - exactly 96 beats in order 0..31 ×3.
  - last on beats 31/63/95.
  - data stable while stalled.
  - FIFO never overflows (assert `fifo_count ≤ 3`).
- num_passes=0 → identical to one pass (32 beats, one done).
- start pulsed in mid-RUN → ignored, beat count unchanged, single done.
- Ready held 0 for 20 cycles after start → at most 3 issues, valid high, no loss; release → all 32 beats in order.
- rst asserted after beat 10 → outputs at reset values next cycle. No valid for 5 cycles afterward. A new start yields a clean 0..31 stream.
